// File: rtl/ctrl_pkg.sv
// Shared control definitions for the five-stage CPU: opcodes, the control
// bundle carried down the pipeline, and the bubble value.
package ctrl_pkg;

  localparam int CTRL_OP_W    = 6;
  localparam int CTRL_ALUOP_W = 3;
  localparam int CTRL_RA_W    = 5;

  localparam logic [CTRL_OP_W-1:0] OP_ADD  = 6'h00;
  localparam logic [CTRL_OP_W-1:0] OP_SUB  = 6'h01;
  localparam logic [CTRL_OP_W-1:0] OP_AND  = 6'h02;
  localparam logic [CTRL_OP_W-1:0] OP_XOR  = 6'h03;
  localparam logic [CTRL_OP_W-1:0] OP_COM  = 6'h04;
  localparam logic [CTRL_OP_W-1:0] OP_MUL  = 6'h05;
  localparam logic [CTRL_OP_W-1:0] OP_ADDI = 6'h08;
  localparam logic [CTRL_OP_W-1:0] OP_LW   = 6'h18;
  localparam logic [CTRL_OP_W-1:0] OP_SW   = 6'h28;
  localparam logic [CTRL_OP_W-1:0] OP_BEQ  = 6'h31;

  typedef struct packed {
    logic                    wen;
    logic                    alusrc;
    logic                    memrd;
    logic                    memwr;
    logic                    illegal;
    logic [CTRL_ALUOP_W-1:0] aluop;
    logic [CTRL_RA_W-1:0]    rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the control bundle for an ID-stage
// instruction and whether it reads rt as a source operand.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ZERO_REG = 1
) (
  input  logic [CTRL_OP_W-1:0] opcode_i,
  input  logic [CTRL_RA_W-1:0] rt_i,
  input  logic [CTRL_RA_W-1:0] rd_i,
  output ctrl_bundle_t         ctrl_o,
  output logic                 uses_rt_o
);

  always_comb begin
    ctrl_o       = CTRL_BUBBLE;
    uses_rt_o    = 1'b0;
    ctrl_o.aluop = opcode_i[CTRL_ALUOP_W-1:0];
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: begin
        ctrl_o.wen = 1'b1;
        ctrl_o.rd  = rd_i;
        uses_rt_o  = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.wen    = 1'b1;
        ctrl_o.alusrc = 1'b1;
        ctrl_o.rd     = rt_i;
      end
      OP_LW: begin
        ctrl_o.wen    = 1'b1;
        ctrl_o.alusrc = 1'b1;
        ctrl_o.memrd  = 1'b1;
        ctrl_o.rd     = rt_i;
      end
      OP_SW: begin
        ctrl_o.alusrc = 1'b1;
        ctrl_o.memwr  = 1'b1;
        uses_rt_o     = 1'b1;
      end
      OP_BEQ: begin
        uses_rt_o = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
    // Register 0 is hardwired; never let a write to it reach WB.
    if ((ZERO_REG != 0) && (ctrl_o.rd == '0)) begin
      ctrl_o.wen = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use hazard detection with a one-cycle stall, and a stall counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3,
  parameter int RA_W     = 5,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid_i,
  input  logic [OP_W-1:0]    id_opcode_i,
  input  logic [RA_W-1:0]    id_rs_i,
  input  logic [RA_W-1:0]    id_rt_i,
  input  logic [RA_W-1:0]    id_rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic               ex_wen_o,
  output logic               ex_alusrc_o,
  output logic               ex_memrd_o,
  output logic               ex_memwr_o,
  output logic               ex_illegal_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic [RA_W-1:0]    ex_rd_o,
  output logic               mem_wen_o,
  output logic               mem_memrd_o,
  output logic               mem_memwr_o,
  output logic [RA_W-1:0]    mem_rd_o,
  output logic               wb_wen_o,
  output logic [RA_W-1:0]    wb_rd_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  ctrl_bundle_t id_ctrl;
  logic         id_uses_rt;
  logic         hazard;
  logic         load_id;

  ctrl_bundle_t ex_d, ex_q;
  logic         ex_valid_d, ex_valid_q;
  ctrl_bundle_t mem_q;
  ctrl_bundle_t wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  ctrl_decode #(
    .ZERO_REG (ZERO_REG)
  ) u_decode (
    .opcode_i  (id_opcode_i),
    .rt_i      (id_rt_i),
    .rd_i      (id_rd_i),
    .ctrl_o    (id_ctrl),
    .uses_rt_o (id_uses_rt)
  );

  // A load in EX whose result the ID instruction reads cannot be forwarded in time.
  always_comb begin
    hazard = ex_valid_q && ex_q.memrd && (ex_q.rd != '0) &&
             ((ex_q.rd == id_rs_i) || (id_uses_rt && (ex_q.rd == id_rt_i)));
    stall_o = id_valid_i && hazard && !flush_i;
    load_id = id_valid_i && !stall_o && !flush_i;
  end

  always_comb begin
    ex_d       = CTRL_BUBBLE;
    ex_valid_d = 1'b0;
    if (load_id) begin
      ex_d       = id_ctrl;
      ex_valid_d = 1'b1;
    end
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= CTRL_BUBBLE;
      ex_valid_q <= 1'b0;
      mem_q      <= CTRL_BUBBLE;
      wb_q       <= CTRL_BUBBLE;
      cnt_q      <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      mem_q      <= ex_q;
      wb_q       <= mem_q;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_wen_o     = ex_q.wen;
  assign ex_alusrc_o  = ex_q.alusrc;
  assign ex_memrd_o   = ex_q.memrd;
  assign ex_memwr_o   = ex_q.memwr;
  assign ex_illegal_o = ex_q.illegal;
  assign ex_aluop_o   = ex_q.aluop;
  assign ex_rd_o      = ex_q.rd;
  assign mem_wen_o    = mem_q.wen;
  assign mem_memrd_o  = mem_q.memrd;
  assign mem_memwr_o  = mem_q.memwr;
  assign mem_rd_o     = mem_q.rd;
  assign wb_wen_o     = wb_q.wen;
  assign wb_rd_o      = wb_q.rd;
  assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode, pipeline latency, load-use stalls,
// flush priority, illegal/zero-register handling, counter saturation, reset.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_i;
  logic [5:0] id_opcode_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic       flush_i;
  logic       stall_o;
  logic       ex_valid_o, ex_wen_o, ex_alusrc_o, ex_memrd_o, ex_memwr_o, ex_illegal_o;
  logic [2:0] ex_aluop_o;
  logic [4:0] ex_rd_o;
  logic       mem_wen_o, mem_memrd_o, mem_memwr_o;
  logic [4:0] mem_rd_o;
  logic       wb_wen_o;
  logic [4:0] wb_rd_o;
  logic [1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(
    .OP_W(6), .ALUOP_W(3), .RA_W(5), .CNT_W(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .flush_i(flush_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_wen_o(ex_wen_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_memrd_o(ex_memrd_o), .ex_memwr_o(ex_memwr_o), .ex_illegal_o(ex_illegal_o),
    .ex_aluop_o(ex_aluop_o), .ex_rd_o(ex_rd_o),
    .mem_wen_o(mem_wen_o), .mem_memrd_o(mem_memrd_o), .mem_memwr_o(mem_memwr_o),
    .mem_rd_o(mem_rd_o), .wb_wen_o(wb_wen_o), .wb_rd_o(wb_rd_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic fl);
    id_valid_i  = v;
    id_opcode_i = op;
    id_rs_i     = rs;
    id_rt_i     = rt;
    id_rd_i     = rd;
    flush_i     = fl;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    v = {ex_valid_o, ex_wen_o, ex_alusrc_o, ex_memrd_o, ex_memwr_o, ex_illegal_o,
         ex_aluop_o, ex_rd_o, mem_wen_o, mem_memrd_o, mem_memwr_o, mem_rd_o,
         wb_wen_o, wb_rd_o, stall_cnt_o};
    check({tag, "_regs"}, v, 32'h0);
    check({tag, "_stall"}, {31'b0, stall_o}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    issue(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check_all_zero("reset");
    #5 rst_n = 1'b1;
    tick();

    // ADD r3: latency 1/2/3 to EX/MEM/WB
    issue(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
    check("add_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("add_ex_valid", {31'b0, ex_valid_o}, 32'd1);
    check("add_ex_wen", {31'b0, ex_wen_o}, 32'd1);
    check("add_ex_aluop", {29'b0, ex_aluop_o}, 32'd0);
    check("add_ex_alusrc", {31'b0, ex_alusrc_o}, 32'd0);
    check("add_ex_rd", {27'b0, ex_rd_o}, 32'd3);
    issue(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check("add_mem_wen", {31'b0, mem_wen_o}, 32'd1);
    check("add_mem_rd", {27'b0, mem_rd_o}, 32'd3);
    check("bubble_ex_valid", {31'b0, ex_valid_o}, 32'd0);
    tick();
    check("add_wb_wen", {31'b0, wb_wen_o}, 32'd1);
    check("add_wb_rd", {27'b0, wb_rd_o}, 32'd3);

    // LW r4 then dependent ADD on rs
    issue(1'b1, 6'h18, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    check("lw_ex_memrd", {31'b0, ex_memrd_o}, 32'd1);
    check("lw_ex_alusrc", {31'b0, ex_alusrc_o}, 32'd1);
    check("lw_ex_rd", {27'b0, ex_rd_o}, 32'd4);
    issue(1'b1, 6'h00, 5'd4, 5'd7, 5'd8, 1'b0);
    check("lu_stall", {31'b0, stall_o}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'b0, ex_valid_o}, 32'd0);
    check("lu_cnt", {30'b0, stall_cnt_o}, 32'd1);
    check("lu_stall_clear", {31'b0, stall_o}, 32'd0);
    tick();
    check("lu_add_valid", {31'b0, ex_valid_o}, 32'd1);
    check("lu_add_rd", {27'b0, ex_rd_o}, 32'd8);

    // Independent ADD after LW; LW r0 then ADD reading r0
    issue(1'b1, 6'h18, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    issue(1'b1, 6'h00, 5'd5, 5'd6, 5'd9, 1'b0);
    check("nodep_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("nodep_ex_rd", {27'b0, ex_rd_o}, 32'd9);
    issue(1'b1, 6'h18, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    check("lw_r0_wen", {31'b0, ex_wen_o}, 32'd0);
    issue(1'b1, 6'h00, 5'd0, 5'd0, 5'd10, 1'b0);
    check("r0_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("nodep_cnt", {30'b0, stall_cnt_o}, 32'd1);

    // rt dependency stalls for ADD, not for ADDI (rt is its destination)
    issue(1'b1, 6'h18, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    issue(1'b1, 6'h08, 5'd1, 5'd4, 5'd0, 1'b0);
    check("addi_rt_stall", {31'b0, stall_o}, 32'd0);
    issue(1'b1, 6'h00, 5'd1, 5'd4, 5'd11, 1'b0);
    check("rt_stall", {31'b0, stall_o}, 32'd1);
    tick();
    check("rt_cnt", {30'b0, stall_cnt_o}, 32'd2);
    tick();

    // Flush beats stall
    issue(1'b1, 6'h18, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    issue(1'b1, 6'h08, 5'd4, 5'd5, 5'd0, 1'b1);
    check("flush_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("flush_ex_valid", {31'b0, ex_valid_o}, 32'd0);
    check("flush_ex_wen", {31'b0, ex_wen_o}, 32'd0);
    check("flush_cnt", {30'b0, stall_cnt_o}, 32'd2);

    // Illegal opcode, ADD to r0, SW
    issue(1'b1, 6'h3F, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    check("ill_flag", {31'b0, ex_illegal_o}, 32'd1);
    check("ill_wen", {31'b0, ex_wen_o}, 32'd0);
    check("ill_mem", {30'b0, ex_memrd_o, ex_memwr_o}, 32'd0);
    check("ill_aluop", {29'b0, ex_aluop_o}, 32'd7);
    issue(1'b1, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    check("add_r0_wen", {31'b0, ex_wen_o}, 32'd0);
    check("add_r0_valid", {31'b0, ex_valid_o}, 32'd1);
    issue(1'b1, 6'h28, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    check("sw_ex", {28'b0, ex_wen_o, ex_alusrc_o, ex_memrd_o, ex_memwr_o}, 32'b0101);
    issue(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check("sw_mem_memwr", {31'b0, mem_memwr_o}, 32'd1);

    // Chain of dependent loads: one stall each, counter saturates at 3
    #2 rst_n = 1'b0;
    #1 check("rst2_cnt", {30'b0, stall_cnt_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    issue(1'b1, 6'h18, 5'd0, 5'd4, 5'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 6'h18, 5'(4 + i), 5'(5 + i), 5'd0, 1'b0);
      check($sformatf("chain%0d_stall", i), {31'b0, stall_o}, 32'd1);
      tick();
      check($sformatf("chain%0d_cnt", i), {30'b0, stall_cnt_o}, (i < 3) ? i + 1 : 3);
      check($sformatf("chain%0d_release", i), {31'b0, stall_o}, 32'd0);
      tick();
      check($sformatf("chain%0d_ex_rd", i), {27'b0, ex_rd_o}, 5 + i);
    end

    // Async reset mid-pipeline
    issue(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    issue(1'b1, 6'h00, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    issue(1'b1, 6'h00, 5'd1, 5'd2, 5'd6, 1'b0);
    tick();
    check("pre_rst_wb_wen", {31'b0, wb_wen_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
